// File: rtl/bk_operand_stager.sv
// bk_operand_stager
//   Operand/result stage wrapped around an external 12-bit Brent-Kung adder.
//   Operand pairs arrive on a valid/ready stream and are buffered in a small
//   FIFO. The head pair is driven, bit-interleaved, onto the adder's INPUTS
//   bus. The adder's OUTS bus is captured into a registered valid/ready result
//   port. A saturating counter tracks how many results carried out.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair valid          in_ready   FIFO can accept
//   in_a/in_b  operands (WIDTH bits)
//   adder_in   interleaved head pair: adder_in[2i]=a[i], adder_in[2i+1]=b[i]
//   adder_out  adder result: [WIDTH-1:0]=sum, [WIDTH]=carry
//   res_valid  result register full        res_ready  consumer accepts
//   res_sum    registered sum               res_cout   registered carry-out
//   cout_cnt   saturating count of results with carry-out set
module bk_operand_stager #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [2*WIDTH-1:0] adder_in,
    input  logic [WIDTH:0]     adder_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_sum,
    output logic               res_cout,
    output logic [CNTW-1:0]    cout_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Each entry holds {a, b}
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_sum_q, res_sum_d;
    logic               res_cout_q, res_cout_d;
    logic [CNTW-1:0]    cout_cnt_q, cout_cnt_d;

    logic               push;
    logic               cap;
    logic               not_empty;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_a, head_b;

    // in_ready depends only on the registered count, so a pop at the same
    // edge never lets a full FIFO accept (no pass-through).
    assign in_ready  = (count_q < CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign cap       = not_empty && (!res_valid_q || res_ready);

    // Empty FIFO presents zero operands to the adder.
    assign head   = not_empty ? mem_q[rd_ptr_q] : '0;
    assign head_a = head[2*WIDTH-1:WIDTH];
    assign head_b = head[WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_interleave
            assign adder_in[2*gi]   = head_a[gi];
            assign adder_in[2*gi+1] = head_b[gi];
        end
    endgenerate

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        cout_cnt_d  = cout_cnt_q;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (cap) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, cap})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (cap) begin
            res_sum_d   = adder_out[WIDTH-1:0];
            res_cout_d  = adder_out[WIDTH];
            res_valid_d = 1'b1;
            if (adder_out[WIDTH] && (cout_cnt_q != '1)) begin
                cout_cnt_d = cout_cnt_q + CNTW'(1);
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            cout_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            cout_cnt_q  <= cout_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign cout_cnt  = cout_cnt_q;
endmodule

// File: tb/tb_bk_operand_stager.sv
module tb_bk_operand_stager;
    localparam int W = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [2*W-1:0] adder_in;
    logic [W:0]    adder_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_sum;
    logic          res_cout;
    logic [7:0]    cout_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted pairs' expected {cout,sum}, in order.
    logic [W:0] exp_q[$];
    int         carries = 0;

    always #5 clk = ~clk;

    bk_operand_stager #(.WIDTH(W), .DEPTH(2), .CNTW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .adder_in(adder_in), .adder_out(adder_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout),
        .cout_cnt(cout_cnt)
    );

    // Stand-in for the external adder: de-interleave and add.
    always_comb begin
        logic [W-1:0] aa, bb;
        aa = '0;
        bb = '0;
        for (int i = 0; i < W; i++) begin
            aa[i] = adder_in[2*i];
            bb[i] = adder_in[2*i+1];
        end
        adder_out = {1'b0, aa} + {1'b0, bb};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] interleave(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    function automatic int exp_cnt();
        return (carries > 255) ? 255 : carries;
    endfunction

    // One clock: observe handshakes before the edge, update the model after.
    task automatic cycle();
        logic       push, pop;
        logic [W:0] got, exp;
        push = in_valid && in_ready;
        pop  = res_valid && res_ready;
        got  = {res_cout, res_sum};
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            carries = 0;
        end else begin
            if (pop) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", {19'd0, got}, 32'hDEAD);
                end else begin
                    exp = exp_q.pop_front();
                    chk("result", {19'd0, got}, {19'd0, exp});
                    $display("result sum=%03h cout=%0d", got[W-1:0], got[W]);
                end
            end
            if (push) begin
                exp = {1'b0, in_a} + {1'b0, in_b};
                exp_q.push_back(exp);
                if (exp[W]) carries++;
            end
        end
        #1;
    endtask

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            cycle();
            n++;
        end
        if (n >= 50) chk("push_timeout", 32'd1, 32'd0);
        cycle();
        $display("push a=%03h b=%03h", a, b);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_sum", {20'd0, res_sum}, 32'd0);
        chk("rst_res_cout", {31'd0, res_cout}, 32'd0);
        chk("rst_cout_cnt", {24'd0, cout_cnt}, 32'd0);
        chk("rst_adder_in", {8'd0, adder_in}, 32'd0);

        // 1: interleave and latency
        res_ready = 1'b0;
        push_pair(12'hAAA, 12'h555);
        chk("t1_adder_in", {8'd0, adder_in}, 32'h666666);
        chk("t1_not_yet_valid", {31'd0, res_valid}, 32'd0);
        cycle();
        chk("t1_valid", {31'd0, res_valid}, 32'd1);
        chk("t1_sum", {20'd0, res_sum}, 32'hFFF);
        chk("t1_cout", {31'd0, res_cout}, 32'd0);
        chk("t1_adder_in_empty", {8'd0, adder_in}, 32'd0);
        drain();

        // 2: carry
        res_ready = 1'b1;
        push_pair(12'hFFF, 12'h001);
        cycle();
        chk("t2_sum", {20'd0, res_sum}, 32'h000);
        chk("t2_cout", {31'd0, res_cout}, 32'd1);
        chk("t2_cnt1", {24'd0, cout_cnt}, 32'd1);
        push_pair(12'h800, 12'h800);
        drain();
        chk("t2_cnt2", {24'd0, cout_cnt}, exp_cnt());

        // 3: back-pressure, then 1 result per cycle
        res_ready = 1'b0;
        push_pair(12'h123, 12'h456);
        push_pair(12'h7FF, 12'h801);
        push_pair(12'h0F0, 12'h00F);
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t3_thru_valid", {31'd0, res_valid}, 32'd1);
            cycle();
        end
        chk("t3_empty_valid", {31'd0, res_valid}, 32'd0);
        chk("t3_model_empty", exp_q.size(), 32'd0);

        // 4: full with pop at the same edge, then steady push+pop at count 1
        res_ready = 1'b0;
        push_pair(12'h111, 12'h222);
        push_pair(12'h333, 12'h444);
        push_pair(12'h555, 12'h666);
        in_a = 12'hABC; in_b = 12'hDEF; in_valid = 1'b1;
        chk("t4_full_ready", {31'd0, in_ready}, 32'd0);
        cycle();
        chk("t4_no_accept", exp_q.size(), 32'd3);
        res_ready = 1'b1;
        chk("t4_no_passthru", {31'd0, in_ready}, 32'd0);
        cycle();
        chk("t4_pop_only", exp_q.size(), 32'd2);
        for (int k = 0; k < 5; k++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            chk("t4_ready_cnt1", {31'd0, in_ready}, 32'd1);
            cycle();
            chk("t4_steady_size", exp_q.size(), 32'd2);
        end
        drain();
        chk("t4_cnt", {24'd0, cout_cnt}, exp_cnt());

        // Random traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            in_a = W'($urandom);
            in_b = W'($urandom);
            if (in_valid && in_ready)
                chk("rnd_adder_in_ok", 32'd1, {31'd0, (exp_q.size() >= 1) || (adder_in == 24'd0)});
            cycle();
        end
        drain();
        chk("rnd_cnt", {24'd0, cout_cnt}, exp_cnt());

        // 5: reset mid-stream
        res_ready = 1'b0;
        push_pair(12'h001, 12'h002);
        push_pair(12'hFFF, 12'hFFF);
        push_pair(12'h003, 12'h004);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_valid", {31'd0, res_valid}, 32'd0);
        chk("t5_cnt", {24'd0, cout_cnt}, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t5_no_stale", {31'd0, res_valid}, 32'd0);
        end

        // 6: saturation
        for (int k = 0; k < 260; k++) push_pair(12'hFFF, 12'hFFF);
        drain();
        chk("t6_sat", {24'd0, cout_cnt}, 32'hFF);
        chk("t6_model_sat", {24'd0, cout_cnt}, exp_cnt());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
